// File: rtl/led_fader.sv
// ---------------------------------------------------------------------------
// led_fader
//
// Multi-channel LED driver. Each channel is independently off, on, blinking
// or breathing (triangle PWM fade). A single free-running phase counter sets
// the PWM period for every channel. Mode and step inputs are only looked at
// on the last clock of a PWM period, so a channel never changes behaviour in
// the middle of a period.
//
// Ports
//   i_clk     clock
//   i_rst     synchronous reset, active high
//   i_mode    per-channel mode, channel n at [2n+1:2n]
//             00 off, 01 on, 10 blink, 11 breathe
//   i_step    per-channel breathe increment per PWM period,
//             channel n at [P_STEP_BITS*n +: P_STEP_BITS]
//   o_led     registered LED drive, one bit per channel
//   o_period  high for the last cycle of every PWM period
//
// Per-channel FSM
//   state        | meaning
//   -------------+-------------------------------------------------
//   S_OFF        | LED dark
//   S_ON         | LED fully lit (100 % duty)
//   S_BLINK_ON   | blink, lit half-cycle
//   S_BLINK_OFF  | blink, dark half-cycle
//   S_RAMP_UP    | breathe, level rising by step each period
//   S_RAMP_DOWN  | breathe, level falling by step each period
// ---------------------------------------------------------------------------
module led_fader #(
    parameter int P_CHANNELS      = 3,
    parameter int P_PWM_BITS      = 8,
    parameter int P_STEP_BITS     = 4,
    parameter int P_BLINK_PERIODS = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [2*P_CHANNELS-1:0]           i_mode,
    input  logic [P_STEP_BITS*P_CHANNELS-1:0] i_step,
    output logic [P_CHANNELS-1:0]             o_led,
    output logic                              o_period
);

    // Breathe arithmetic is done one bit wider than the level (and never
    // narrower than the step plus one bit) so a sum can never wrap.
    localparam int AW = (P_STEP_BITS + 1 > P_PWM_BITS + 1) ? P_STEP_BITS + 1 : P_PWM_BITS + 1;
    localparam int BW = (P_BLINK_PERIODS > 1) ? $clog2(P_BLINK_PERIODS) : 1;

    localparam logic [P_PWM_BITS-1:0] PHASE_MAX   = '1;
    localparam logic [P_PWM_BITS-1:0] PHASE_ONE   = P_PWM_BITS'(1);
    localparam logic [AW-1:0]         LEVEL_MAX_X = AW'({P_PWM_BITS{1'b1}});
    localparam logic [AW-1:0]         STEP_ZERO_X = '0;
    localparam logic [BW-1:0]         BLINK_LAST  = BW'(P_BLINK_PERIODS - 1);
    localparam logic [BW-1:0]         BLINK_ONE   = BW'(1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_ON        = 3'd1,
        S_BLINK_ON  = 3'd2,
        S_BLINK_OFF = 3'd3,
        S_RAMP_UP   = 3'd4,
        S_RAMP_DOWN = 3'd5
    } state_t;

    // Mode encoding that a state belongs to; a boundary only restarts a
    // channel when the sampled mode leaves this group.
    function automatic logic [1:0] group_of(input state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            S_OFF:                    g = 2'b00;
            S_ON:                     g = 2'b01;
            S_BLINK_ON, S_BLINK_OFF:  g = 2'b10;
            S_RAMP_UP, S_RAMP_DOWN:   g = 2'b11;
            default:                  g = 2'b00;
        endcase
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // Shared phase counter
    // -----------------------------------------------------------------------
    logic [P_PWM_BITS-1:0] phase_q;
    logic [P_PWM_BITS-1:0] phase_d;
    logic                  boundary;

    assign boundary = (phase_q == PHASE_MAX);
    assign phase_d  = phase_q + PHASE_ONE;
    assign o_period = boundary;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel state machines
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
        state_t                state_q;
        state_t                state_d;
        logic [P_PWM_BITS-1:0] level_q;
        logic [P_PWM_BITS-1:0] level_d;
        logic [BW-1:0]         blink_q;
        logic [BW-1:0]         blink_d;
        logic                  led_q;
        logic                  led_d;
        logic [1:0]            mode_s;
        logic [AW-1:0]         step_x;
        logic [AW-1:0]         level_x;
        logic [AW-1:0]         sum_x;
        logic [AW-1:0]         diff_x;

        assign mode_s  = i_mode[2*g +: 2];
        assign step_x  = AW'(i_step[P_STEP_BITS*g +: P_STEP_BITS]);
        assign level_x = AW'(level_q);
        assign sum_x   = level_x + step_x;
        assign diff_x  = level_x - step_x;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q <= S_OFF;
                level_q <= '0;
                blink_q <= '0;
                led_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                level_q <= level_d;
                blink_q <= blink_d;
                led_q   <= led_d;
            end
        end

        always_comb begin
            state_d = state_q;
            level_d = level_q;
            blink_d = blink_q;
            led_d   = 1'b0;

            if (boundary) begin
                if (mode_s != group_of(state_q)) begin
                    case (mode_s)
                        2'b00: state_d = S_OFF;
                        2'b01: state_d = S_ON;
                        2'b10: begin
                            state_d = S_BLINK_ON;
                            blink_d = '0;
                        end
                        default: begin
                            state_d = S_RAMP_UP;
                            level_d = '0;
                        end
                    endcase
                end else begin
                    case (state_q)
                        S_BLINK_ON, S_BLINK_OFF: begin
                            if (blink_q == BLINK_LAST) begin
                                blink_d = '0;
                                state_d = (state_q == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                            end else begin
                                blink_d = blink_q + BLINK_ONE;
                            end
                        end
                        // Direction reverses in the period the level lands on
                        // an end stop, so the peak and the trough each last a
                        // single period. A zero step freezes the fade entirely.
                        S_RAMP_UP: begin
                            if (step_x != STEP_ZERO_X) begin
                                if (sum_x >= LEVEL_MAX_X) begin
                                    level_d = PHASE_MAX;
                                    state_d = S_RAMP_DOWN;
                                end else begin
                                    level_d = sum_x[P_PWM_BITS-1:0];
                                end
                            end
                        end
                        S_RAMP_DOWN: begin
                            if (step_x != STEP_ZERO_X) begin
                                if (step_x >= level_x) begin
                                    level_d = '0;
                                    state_d = S_RAMP_UP;
                                end else begin
                                    level_d = diff_x[P_PWM_BITS-1:0];
                                end
                            end
                        end
                        S_OFF, S_ON: begin
                            state_d = state_q;
                        end
                        default: begin
                            state_d = S_OFF;
                        end
                    endcase
                end
            end

            // The output register holds the value for the phase that follows,
            // so it is computed from the next state, level and phase.
            case (state_d)
                S_ON, S_BLINK_ON:       led_d = 1'b1;
                S_RAMP_UP, S_RAMP_DOWN: led_d = (level_d > phase_d);
                default:                led_d = 1'b0;
            endcase
        end

        assign o_led[g] = led_q;
    end

endmodule
